// File: rtl/sparc_decode_pkg.sv
// rtl/sparc_decode_pkg.sv - shared types, SPARC opcode constants and operand-usage decode
package sparc_decode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    STALL = 2'd2
  } state_e;

  localparam logic [1:0] OP_BRANCH     = 2'b00;
  localparam logic [1:0] OP_CALL       = 2'b01;
  localparam logic [1:0] OP_ALU        = 2'b10;
  localparam logic [1:0] OP_MEM        = 2'b11;
  localparam logic [2:0] OP2_SETHI     = 3'b100;
  localparam logic [4:0] CALL_LINK_REG = 5'd15;

  typedef struct packed {
    logic rs1_en;
    logic rs2_en;
    logic rd_src_en;
    logic dst_en;
    logic dst_link;
  } dec_info_t;

  // Which register fields an instruction reads and writes; r0 filtering is left to the caller.
  function automatic dec_info_t decode_info(input logic [31:0] inst);
    dec_info_t info;
    logic      store;
    info  = '0;
    store = inst[21];
    case (inst[31:30])
      OP_CALL: begin
        info.dst_en   = 1'b1;
        info.dst_link = 1'b1;
      end
      OP_BRANCH: info.dst_en = (inst[24:22] == OP2_SETHI);
      OP_ALU: begin
        info.rs1_en = 1'b1;
        info.rs2_en = !inst[13];
        info.dst_en = 1'b1;
      end
      OP_MEM: begin
        info.rs1_en    = 1'b1;
        info.rs2_en    = !inst[13];
        info.rd_src_en = store;
        info.dst_en    = !store;
      end
      default: info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/sparc_decode_regfile.sv
// rtl/sparc_decode_regfile.sv - 3-read/1-write register file with write-through, r0 hardwired to 0
module decode_regfile #(
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr_a_i,
  input  logic [REG_ADDR_W-1:0] raddr_b_i,
  input  logic [REG_ADDR_W-1:0] raddr_d_i,
  output logic [DATA_W-1:0]     rdata_a_o,
  output logic [DATA_W-1:0]     rdata_b_o,
  output logic [DATA_W-1:0]     rdata_d_o
);

  logic [DATA_W-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < REG_COUNT; k++) mem_q[k] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 :
                     (we_i && waddr_i == raddr_a_i) ? wdata_i : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 :
                     (we_i && waddr_i == raddr_b_i) ? wdata_i : mem_q[raddr_b_i];
  assign rdata_d_o = (raddr_d_i == '0) ? '0 :
                     (we_i && waddr_i == raddr_d_i) ? wdata_i : mem_q[raddr_d_i];

endmodule

// File: rtl/sparc_decode_stage.sv
// rtl/sparc_decode_stage.sv - SPARC decode stage: one-slot hold, scoreboard RAW/structural stalls
// Optional DECODE_PERF_EN adds perf_stall_cycles / perf_issued counters.
module sparc_decode_stage
  import sparc_decode_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_INST_WIDTH = 32,
  parameter int REG_COUNT      = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int SB_CNT_W       = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_DATA_WIDTH-1:0] in_PCplus4,
  input  logic [BUS_INST_WIDTH-1:0] inst,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      flush,
  input  logic                      wb_en,
  input  logic [REG_ADDR_W-1:0]     wb_addr,
  input  logic [BUS_INST_WIDTH-1:0] wb_data,
`ifdef DECODE_PERF_EN
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_issued,
`endif
  output logic [BUS_DATA_WIDTH-1:0] out_PCplus4,
  output logic [BUS_INST_WIDTH-1:0] valA,
  output logic [BUS_INST_WIDTH-1:0] valB,
  output logic [BUS_INST_WIDTH-1:0] valD,
  output logic [1:0]                op,
  output logic [2:0]                op2,
  output logic [5:0]                op3,
  output logic [3:0]                cond,
  output logic                      a,
  output logic                      i,
  output logic [4:0]                rd,
  output logic [12:0]               imm13,
  output logic [21:0]               disp22,
  output logic [29:0]               disp30
);

  localparam logic [SB_CNT_W-1:0] SB_MAX = {SB_CNT_W{1'b1}};

  state_e                    state_q, state_d, state_cur;
  logic [BUS_INST_WIDTH-1:0] inst_q;
  logic [BUS_DATA_WIDTH-1:0] pc_q;
  logic [SB_CNT_W-1:0]       sb_q [REG_COUNT];
  logic [SB_CNT_W-1:0]       sb_d [REG_COUNT];

  dec_info_t             info;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr, rd_addr, dst_addr;
  logic                  dst_en;
  logic                  hazard, issue, accept;

  assign info     = decode_info(inst_q[31:0]);
  assign rs1_addr = inst_q[14 +: REG_ADDR_W];
  assign rs2_addr = inst_q[0 +: REG_ADDR_W];
  assign rd_addr  = inst_q[25 +: REG_ADDR_W];
  assign dst_addr = info.dst_link ? REG_ADDR_W'(CALL_LINK_REG) : rd_addr;
  assign dst_en   = info.dst_en && (dst_addr != '0);

  // A lone in-flight writer retiring this very cycle is covered by the regfile bypass.
  function automatic logic src_blocked(input logic [SB_CNT_W-1:0] cnt, input logic wb_hit);
    return (cnt != '0) && !((cnt == SB_CNT_W'(1)) && wb_hit);
  endfunction

  always_comb begin
    hazard = 1'b0;
    if (info.rs1_en && src_blocked(sb_q[rs1_addr], wb_en && wb_addr == rs1_addr))
      hazard = 1'b1;
    if (info.rs2_en && src_blocked(sb_q[rs2_addr], wb_en && wb_addr == rs2_addr))
      hazard = 1'b1;
    if (info.rd_src_en && src_blocked(sb_q[rd_addr], wb_en && wb_addr == rd_addr))
      hazard = 1'b1;
    if (dst_en && sb_q[dst_addr] == SB_MAX)
      hazard = 1'b1;
  end

  // The stored state only distinguishes empty from occupied; READY/STALL follow the live hazard.
  always_comb begin
    state_cur = IDLE;
    if (state_q != IDLE) state_cur = hazard ? STALL : READY;
  end

  assign out_valid = !reset && (state_cur == READY);
  assign in_ready  = !reset && !flush &&
                     ((state_cur == IDLE) || ((state_cur == READY) && out_ready));
  assign issue     = out_valid && out_ready && !flush;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d = state_cur;
    if (flush)       state_d = IDLE;
    else if (accept) state_d = READY;
    else if (issue)  state_d = IDLE;
  end

  always_comb begin
    logic inc, dec;
    for (int k = 0; k < REG_COUNT; k++) begin
      inc     = issue && dst_en && (dst_addr == REG_ADDR_W'(k));
      dec     = wb_en && (wb_addr == REG_ADDR_W'(k));
      sb_d[k] = sb_q[k];
      if (inc && !dec)
        sb_d[k] = sb_q[k] + SB_CNT_W'(1);
      else if (dec && !inc && sb_q[k] != '0)
        sb_d[k] = sb_q[k] - SB_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      inst_q  <= '0;
      pc_q    <= '0;
      for (int k = 0; k < REG_COUNT; k++) sb_q[k] <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      if (accept) begin
        inst_q <= inst;
        pc_q   <= in_PCplus4;
      end
    end
  end

  decode_regfile #(
    .REG_COUNT (REG_COUNT),
    .REG_ADDR_W(REG_ADDR_W),
    .DATA_W    (BUS_INST_WIDTH)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we_i     (wb_en),
    .waddr_i  (wb_addr),
    .wdata_i  (wb_data),
    .raddr_a_i(rs1_addr),
    .raddr_b_i(rs2_addr),
    .raddr_d_i(rd_addr),
    .rdata_a_o(valA),
    .rdata_b_o(valB),
    .rdata_d_o(valD)
  );

  assign out_PCplus4 = pc_q;
  assign op          = inst_q[31:30];
  assign op2         = inst_q[24:22];
  assign op3         = inst_q[24:19];
  assign cond        = inst_q[28:25];
  assign a           = inst_q[29];
  assign i           = inst_q[13];
  assign rd          = inst_q[29:25];
  assign imm13       = inst_q[12:0];
  assign disp22      = inst_q[21:0];
  assign disp30      = inst_q[29:0];

`ifdef DECODE_PERF_EN
  logic [31:0] perf_stall_q, perf_issued_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q  <= '0;
      perf_issued_q <= '0;
    end else begin
      if (state_cur == STALL) perf_stall_q  <= perf_stall_q + 32'd1;
      if (issue)              perf_issued_q <= perf_issued_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_issued       = perf_issued_q;
`endif

endmodule

// File: tb/tb_sparc_decode_stage.sv
// tb/tb_sparc_decode_stage.sv - directed + random bench with a behavioural decode/scoreboard model
module tb_sparc_decode_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready, flush, wb_en;
  logic        in_ready, out_valid;
  logic [63:0] in_PCplus4, out_PCplus4;
  logic [31:0] inst, wb_data, valA, valB, valD;
  logic [4:0]  wb_addr, rd;
  logic [1:0]  op;
  logic [2:0]  op2;
  logic [5:0]  op3;
  logic [3:0]  cond;
  logic        a, i;
  logic [12:0] imm13;
  logic [21:0] disp22;
  logic [29:0] disp30;

  always #5 clk = ~clk;

  sparc_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_PCplus4(in_PCplus4), .inst(inst), .out_valid(out_valid), .out_ready(out_ready),
    .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_PCplus4(out_PCplus4), .valA(valA), .valB(valB), .valD(valD),
    .op(op), .op2(op2), .op3(op3), .cond(cond), .a(a), .i(i), .rd(rd),
    .imm13(imm13), .disp22(disp22), .disp30(disp30)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural registers, writer counts, the one held instruction.
  logic [31:0] m_regs [32];
  int          m_cnt  [32];
  bit          m_held;
  logic [31:0] m_inst;
  logic [63:0] m_pc;
  int          pend_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input int r);
    if (r == 0) return 32'h0;
    if (wb_en && int'(wb_addr) == r) return wb_data;
    return m_regs[r];
  endfunction

  // Sources and destination by SPARC format; -1 means none.
  function automatic void m_decode(input logic [31:0] x, output int r1, output int r2,
                                   output int rs, output int dst);
    int rdf;
    rdf = int'(x[29:25]);
    r1 = -1; r2 = -1; rs = -1; dst = -1;
    case (x[31:30])
      2'd1: dst = 15;
      2'd0: if (x[24:22] == 3'b100) dst = rdf;
      2'd2: begin
        r1 = int'(x[18:14]);
        if (!x[13]) r2 = int'(x[4:0]);
        dst = rdf;
      end
      default: begin
        r1 = int'(x[18:14]);
        if (!x[13]) r2 = int'(x[4:0]);
        if (x[21]) rs = rdf; else dst = rdf;
      end
    endcase
    if (dst == 0) dst = -1;
  endfunction

  function automatic bit m_busy(input int s);
    if (s <= 0 || m_cnt[s] == 0) return 1'b0;
    return !(m_cnt[s] == 1 && wb_en && int'(wb_addr) == s);
  endfunction

  function automatic bit m_hazard();
    int r1, r2, rs, dst;
    if (!m_held) return 1'b0;
    m_decode(m_inst, r1, r2, rs, dst);
    if (m_busy(r1) || m_busy(r2) || m_busy(rs)) return 1'b1;
    return (dst > 0 && m_cnt[dst] >= 3);
  endfunction

  task automatic tick();
    bit hz, ev, eir, iss, acc, same;
    int r1, r2, rs, dst;
    hz  = m_hazard();
    ev  = !reset && m_held && !hz;
    eir = !reset && !flush && (!m_held || (ev && out_ready));
    @(negedge clk);
    check("out_valid", out_valid, ev);
    check("in_ready", in_ready, eir);
    if (!reset) begin
      check("fields", {op, op2, op3, cond, a, i, rd, imm13, disp22, disp30},
            {m_inst[31:30], m_inst[24:22], m_inst[24:19], m_inst[28:25], m_inst[29],
             m_inst[13], m_inst[29:25], m_inst[12:0], m_inst[21:0], m_inst[29:0]});
      check("out_PCplus4", out_PCplus4, m_pc);
      check("valA", valA, m_read(int'(m_inst[18:14])));
      check("valB", valB, m_read(int'(m_inst[4:0])));
      check("valD", valD, m_read(int'(m_inst[29:25])));
    end
    @(posedge clk);
    iss = ev && out_ready && !flush;
    acc = in_valid && eir;
    if (reset) begin
      for (int k = 0; k < 32; k++) begin m_regs[k] = 32'h0; m_cnt[k] = 0; end
      m_held = 1'b0; m_inst = 32'h0; m_pc = 64'h0;
      pend_q.delete();
    end else begin
      m_decode(m_inst, r1, r2, rs, dst);
      same = iss && dst > 0 && wb_en && int'(wb_addr) == dst;
      if (iss && dst > 0) begin
        pend_q.push_back(dst);
        if (!same) m_cnt[dst]++;
      end
      if (wb_en && !same && m_cnt[wb_addr] > 0) m_cnt[wb_addr]--;
      if (wb_en && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
      if (flush) m_held = 1'b0;
      else if (acc) begin m_held = 1'b1; m_inst = inst; m_pc = in_PCplus4; end
      else if (iss) m_held = 1'b0;
    end
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [1:0] o, input int rdv, input logic [5:0] o3,
                                     input int rs1v, input bit iv, input int low);
    logic [4:0]  rd5, rs5;
    logic [12:0] lo;
    rd5 = 5'(rdv); rs5 = 5'(rs1v); lo = 13'(low);
    return {o, rd5, o3, rs5, iv, lo};
  endfunction

  function automatic logic [31:0] add(input int rdv, input int rs1v, input int rs2v);
    return mk(2'b10, rdv, 6'h00, rs1v, 1'b0, rs2v);
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x        = $urandom;
    x[29:25] = 5'($urandom_range(0, 15));
    x[18:14] = 5'($urandom_range(0, 15));
    x[4:0]   = 5'($urandom_range(0, 15));
    if (x[31:30] == 2'b00) x[24:22] = ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b010;
    return x;
  endfunction

  task automatic offer(input logic [31:0] x);
    in_valid = 1'b1; inst = x; in_PCplus4 = {$urandom, $urandom};
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb1(input int r, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = 5'(r); wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    while (pend_q.size() > 0) wb1(pend_q.pop_front(), $urandom);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; wb_en = 1'b0;
    wb_addr = 5'd0; wb_data = 32'h0; inst = 32'h0; in_PCplus4 = 64'h0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // RAW-free issue with operands from the regfile
    wb1(1, 32'h11); wb1(2, 32'h22);
    out_ready = 1'b1;
    offer(add(3, 1, 2));
    #1;
    check("t1_valid", out_valid, 1'b1);
    check("t1_valA", valA, 32'h11);
    check("t1_valB", valB, 32'h22);
    check("t1_rd", rd, 5'd3);
    tick();

    // RAW stall released by same-cycle writeback bypass
    offer(add(4, 3, 2));
    #1;
    check("t2_stall", out_valid, 1'b0);
    check("t2_in_ready", in_ready, 1'b0);
    tick(); tick();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h33;
    #1;
    check("t2_bypass_valid", out_valid, 1'b1);
    check("t2_bypass_valA", valA, 32'h33);
    tick();
    wb_en = 1'b0;
    drain();

    // Fourth writer of r5 hits the counter ceiling
    repeat (4) offer(add(5, 0, 0));
    #1;
    check("t3_struct", out_valid, 1'b0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h55;
    #1;
    check("t3_wb_cycle", out_valid, 1'b0);
    tick();
    wb_en = 1'b0;
    #1;
    check("t3_release", out_valid, 1'b1);
    tick();
    drain();

    // Store waits on rd as a source, ignores rs2 field when i=1
    offer(add(6, 0, 0)); offer(add(8, 0, 0)); tick();
    offer(mk(2'b11, 6, 6'h04, 1, 1'b1, 8));
    #1;
    check("t4_stall", out_valid, 1'b0);
    tick();
    wb_en = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    #1;
    check("t4_valid", out_valid, 1'b1);
    check("t4_valD", valD, 32'h66);
    tick();
    wb_en = 1'b0;
    drain();

    // Flush of a stalled instruction keeps the scoreboard
    offer(add(7, 0, 0)); tick();
    offer(add(9, 7, 0));
    flush = 1'b1;
    #1;
    check("t5_flush_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    check("t5_idle_valid", out_valid, 1'b0);
    check("t5_idle_ready", in_ready, 1'b1);
    offer(add(10, 7, 0));
    #1;
    check("t5_cnt_kept", out_valid, 1'b0);
    drain();

    // Back-pressure then full-rate streaming
    offer(add(11, 1, 2));
    out_ready = 1'b0; in_valid = 1'b1; inst = add(12, 1, 2);
    repeat (3) begin
      #1; check("t6_blocked", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1; check("t6_stream", in_ready, 1'b1);
      tick();
      inst = add(13 + n, 1, 2);
    end
    in_valid = 1'b0;
    drain();

    // Randomized traffic
    repeat (1500) begin
      in_valid   = ($urandom_range(0, 1) == 1);
      inst       = rand_inst();
      in_PCplus4 = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      wb_en      = 1'b0;
      if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        wb_en = 1'b1; wb_addr = 5'(pend_q.pop_front()); wb_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        wb_en = 1'b1; wb_addr = 5'($urandom_range(0, 15)); wb_data = $urandom;
      end
      tick();
    end
    flush = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    drain();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
